// File: rtl/shift_register_lanes.sv
// Bidirectional SIPO/PISO shifter moving LANES bits per advance, with word-boundary
// tracking, a one-cycle completed-word pulse and a valid/ready parallel load port.
module shift_register_lanes #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit COVER     = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              advance_i,
    input  logic [LANES-1:0]                  bits_i,
    output logic [LANES-1:0]                  bits_o,
    input  logic                              load_valid_i,
    input  logic [WIDTH-1:0]                  load_data_i,
    output logic                              load_ready_o,
    output logic [WIDTH-1:0]                  value_o,
    output logic [$clog2(WIDTH/LANES):0]      count_o,
    output logic                              busy_o,
    output logic [WIDTH-1:0]                  word_o,
    output logic                              word_valid_o
);

    localparam int SHIFTS = WIDTH / LANES;
    localparam int CW     = $clog2(SHIFTS) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(SHIFTS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_value_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_word_next;
    logic             w_word_valid_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_load_ready;
    logic             w_load_accept;

    // Both slices are legal because WIDTH is strictly larger than LANES.
    assign w_shifted = MSB_FIRST ? {r_value[WIDTH-LANES-1:0], bits_i}
                                 : {bits_i, r_value[WIDTH-1:LANES]};

    assign w_load_ready  = (r_state == IDLE) && !clear_i;
    assign w_load_accept = load_valid_i && w_load_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_value      <= '0;
            r_count      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_value      <= w_value_next;
            r_count      <= w_count_next;
            r_word       <= w_word_next;
            r_word_valid <= w_word_valid_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_value_next      = r_value;
        w_count_next      = r_count;
        w_word_next       = r_word;
        w_word_valid_next = 1'b0;
        if (clear_i) begin
            w_state_next = IDLE;
            w_value_next = '0;
            w_count_next = '0;
        end else if (w_load_accept) begin
            // A simultaneous advance is dropped: the loaded word starts unshifted.
            w_state_next = SHIFT;
            w_value_next = load_data_i;
            w_count_next = '0;
        end else if (advance_i) begin
            w_value_next = w_shifted;
            if (r_state == IDLE) begin
                w_state_next = SHIFT;
                w_count_next = CW'(1);
            end else if (r_count == LAST_COUNT) begin
                w_state_next      = IDLE;
                w_count_next      = '0;
                w_word_next       = w_shifted;
                w_word_valid_next = 1'b1;
            end else begin
                w_count_next = r_count + CW'(1);
            end
        end
    end

    assign bits_o       = MSB_FIRST ? r_value[WIDTH-1 -: LANES] : r_value[LANES-1:0];
    assign load_ready_o = w_load_ready;
    assign value_o      = r_value;
    assign count_o      = r_count;
    assign busy_o       = (r_state == SHIFT);
    assign word_o       = r_word;
    assign word_valid_o = r_word_valid;

    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i) r_count < CW'(SHIFTS));

    generate
        if (COVER) begin : g_cover
            c_word_done: cover property (@(posedge clk_i) disable iff (rst_i) r_word_valid);
            c_load_busy: cover property (@(posedge clk_i) disable iff (rst_i)
                                         load_valid_i && (r_state == SHIFT));
        end
    endgenerate

endmodule

// File: tb/tb_shift_register_lanes.sv
// Bench for shift_register_lanes: an 8x1 MSB-first instance and an 8x2 LSB-first instance,
// vector table plus hand sequences, completed words checked through per-instance queues.
module tb_shift_register_lanes;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: WIDTH=8, LANES=1, MSB first
    logic       a_clr = 1'b0, a_adv = 1'b0, a_bits = 1'b0, a_lv = 1'b0;
    logic [7:0] a_ld = '0;
    logic       a_bits_o, a_ready, a_busy, a_wv;
    logic [7:0] a_value, a_word;
    logic [3:0] a_count;

    // Instance B: WIDTH=8, LANES=2, LSB first
    logic       b_clr = 1'b0, b_adv = 1'b0, b_lv = 1'b0;
    logic [1:0] b_bits = '0;
    logic [7:0] b_ld = '0;
    logic [1:0] b_bits_o;
    logic       b_ready, b_busy, b_wv;
    logic [7:0] b_value, b_word;
    logic [2:0] b_count;

    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];

    shift_register_lanes #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1), .COVER(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(a_clr), .advance_i(a_adv), .bits_i(a_bits),
        .bits_o(a_bits_o), .load_valid_i(a_lv), .load_data_i(a_ld), .load_ready_o(a_ready),
        .value_o(a_value), .count_o(a_count), .busy_o(a_busy), .word_o(a_word),
        .word_valid_o(a_wv)
    );

    shift_register_lanes #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0), .COVER(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(b_clr), .advance_i(b_adv), .bits_i(b_bits),
        .bits_o(b_bits_o), .load_valid_i(b_lv), .load_data_i(b_ld), .load_ready_o(b_ready),
        .value_o(b_value), .count_o(b_count), .busy_o(b_busy), .word_o(b_word),
        .word_valid_o(b_wv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every word_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && a_wv) begin
            if (exp_a_q.size() == 0) check("a_unexpected_pulse", 32'(a_word), 32'hdead);
            else check("a_word_o", 32'(a_word), 32'(exp_a_q.pop_front()));
        end
        if (!rst && b_wv) begin
            if (exp_b_q.size() == 0) check("b_unexpected_pulse", 32'(b_word), 32'hdead);
            else check("b_word_o", 32'(b_word), 32'(exp_b_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_a(input logic b);
        a_adv = 1'b1; a_bits = b;
        tick();
        a_adv = 1'b0;
    endtask

    task automatic adv_b(input logic [1:0] b);
        b_adv = 1'b1; b_bits = b;
        tick();
        b_adv = 1'b0;
    endtask

    // Load a word, then shift ser_in in while recording what is shifted out.
    task automatic run_a(input logic [7:0] ld, input logic [7:0] ser,
                         input logic [7:0] exp_out, input logic [7:0] exp_word);
        logic [7:0] out;
        a_lv = 1'b1; a_ld = ld;
        tick();
        a_lv = 1'b0;
        check("a_load_value", 32'(a_value), 32'(ld));
        check("a_load_busy", 32'(a_busy), 32'd1);
        for (int k = 7; k >= 0; k--) begin
            out[k] = a_bits_o;
            if (k == 0) exp_a_q.push_back(exp_word);
            adv_a(ser[k]);
        end
        check("a_piso_out", 32'(out), 32'(exp_out));
        check("a_sipo_value", 32'(a_value), 32'(exp_word));
        check("a_end_count", 32'(a_count), 32'd0);
        check("a_end_pulse", 32'(a_wv), 32'd1);
    endtask

    task automatic run_b(input logic [7:0] ld, input logic [7:0] ser,
                         input logic [7:0] exp_out, input logic [7:0] exp_word);
        logic [7:0] out;
        b_lv = 1'b1; b_ld = ld;
        tick();
        b_lv = 1'b0;
        check("b_load_value", 32'(b_value), 32'(ld));
        for (int k = 0; k < 4; k++) begin
            out[2*k +: 2] = b_bits_o;
            if (k == 3) exp_b_q.push_back(exp_word);
            adv_b(ser[2*k +: 2]);
        end
        check("b_piso_out", 32'(out), 32'(exp_out));
        check("b_sipo_value", 32'(b_value), 32'(exp_word));
        check("b_end_count", 32'(b_count), 32'd0);
        check("b_end_busy", 32'(b_busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] load_word;
        logic [7:0] ser_in;
        logic [7:0] exp_out;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] seq1;
    logic [7:0] r0, r1;

    initial begin
        r0 = 8'($urandom_range(0, 255));
        r1 = 8'($urandom_range(0, 255));
        vecs[0] = '{8'hc6, 8'h00, 8'hc6, 8'h00};
        vecs[1] = '{8'ha5, 8'h3c, 8'ha5, 8'h3c};
        vecs[2] = '{8'hff, 8'h00, 8'hff, 8'h00};
        vecs[3] = '{8'h00, 8'hff, 8'h00, 8'hff};
        vecs[4] = '{8'h81, 8'h7e, 8'h81, 8'h7e};
        vecs[5] = '{r0, r1, r0, r1};

        #2;
        check("rst_a_value", 32'(a_value), 32'd0);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_a_word", 32'(a_word), 32'd0);
        check("rst_a_pulse", 32'(a_wv), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_a_ready", 32'(a_ready), 32'd1);

        // Pure SIPO from IDLE: 1,0,1,0,0,1,0,1 assembles 0xa5.
        seq1 = 8'ha5;
        for (int k = 7; k >= 0; k--) begin
            if (k == 0) exp_a_q.push_back(8'ha5);
            adv_a(seq1[k]);
            if (k > 0) check("t1_count", 32'(a_count), 32'(8 - k));
            if (k > 0) check("t1_no_pulse", 32'(a_wv), 32'd0);
        end
        check("t1_value", 32'(a_value), 32'ha5);
        check("t1_pulse", 32'(a_wv), 32'd1);
        check("t1_word", 32'(a_word), 32'ha5);
        check("t1_count_end", 32'(a_count), 32'd0);
        tick();
        check("t1_pulse_once", 32'(a_wv), 32'd0);

        // Vector table on both lane configurations.
        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i].load_word, vecs[i].ser_in, vecs[i].exp_out, vecs[i].exp_word);
            run_b(vecs[i].load_word, vecs[i].ser_in, vecs[i].exp_out, vecs[i].exp_word);
        end

        // Load with a concurrent advance, then a refused load while busy.
        a_lv = 1'b1; a_ld = 8'h3c; a_adv = 1'b1; a_bits = 1'b1;
        tick();
        a_adv = 1'b0;
        check("t3_value", 32'(a_value), 32'h3c);
        check("t3_count", 32'(a_count), 32'd0);
        check("t3_busy", 32'(a_busy), 32'd1);
        a_ld = 8'hff;
        check("t3_ready_busy", 32'(a_ready), 32'd0);
        tick();
        a_lv = 1'b0;
        check("t3_value_held", 32'(a_value), 32'h3c);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) exp_a_q.push_back(8'h00);
            adv_a(1'b0);
        end
        tick();

        // Three shifts, five idle cycles, five more shifts assembling 0x96.
        seq1 = 8'h96;
        for (int k = 7; k >= 5; k--) adv_a(seq1[k]);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("t4_count_hold", 32'(a_count), 32'd3);
            check("t4_idle_no_pulse", 32'(a_wv), 32'd0);
        end
        for (int k = 4; k >= 0; k--) begin
            if (k == 0) exp_a_q.push_back(8'h96);
            adv_a(seq1[k]);
        end
        check("t4_value", 32'(a_value), 32'h96);
        check("t4_pulse", 32'(a_wv), 32'd1);

        // Asynchronous reset between clock edges after five shifts.
        for (int k = 0; k < 5; k++) adv_a(1'b1);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_value", 32'(a_value), 32'd0);
        check("t5_rst_count", 32'(a_count), 32'd0);
        check("t5_rst_busy", 32'(a_busy), 32'd0);
        check("t5_rst_word", 32'(a_word), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_post_rst_pulse", 32'(a_wv), 32'd0);

        // Complete 0x5a, then clear on the final shift of the next word.
        seq1 = 8'h5a;
        for (int k = 7; k >= 0; k--) begin
            if (k == 0) exp_a_q.push_back(8'h5a);
            adv_a(seq1[k]);
        end
        for (int k = 0; k < 7; k++) adv_a(1'b1);
        check("t5_pre_clear_count", 32'(a_count), 32'd7);
        a_clr = 1'b1; a_adv = 1'b1; a_bits = 1'b1;
        check("t5_clear_ready", 32'(a_ready), 32'd0);
        tick();
        a_clr = 1'b0; a_adv = 1'b0;
        check("t5_clear_value", 32'(a_value), 32'd0);
        check("t5_clear_count", 32'(a_count), 32'd0);
        check("t5_clear_no_pulse", 32'(a_wv), 32'd0);
        check("t5_clear_word_kept", 32'(a_word), 32'h5a);
        check("t5_clear_busy", 32'(a_busy), 32'd0);

        tick();
        tick();
        check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
